// File: rtl/xbar_result_drain_pkg.sv
// Shared definitions for the crossbar result drain: default geometry of the
// multiply crossbar and the drain FSM state encoding.
package xbar_result_drain_pkg;

  localparam int bitLength       = 32;
  localparam int outputPortCount = 4;
  localparam int selectorLength  = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_CAPTURE    = 3'd2,
    ST_PRESENT    = 3'd3,
    ST_DONE       = 3'd4
  } drain_state_e;

endpackage

// File: rtl/xbar_result_drain.sv
// Walks the multiply-crossbar output mux once all output multipliers report
// done, presenting each product as a valid/ready word followed by a done pulse.
module xbar_result_drain
  import xbar_result_drain_pkg::*;
#(
  parameter int PORTS = outputPortCount,
  parameter int WIDTH = bitLength,
  parameter int SEL_W = selectorLength
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_drain_start,
  input  logic [PORTS-1:0] i_m_ready_out,
  input  logic [WIDTH-1:0] i_data_out,
  output logic [SEL_W-1:0] o_output_select,
  output logic [WIDTH-1:0] o_res_data,
  output logic [SEL_W-1:0] o_res_index,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_busy,
  output logic             o_drain_done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(PORTS - 1);

  drain_state_e     r_state, w_state_nxt;
  logic [SEL_W-1:0] r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_res_data;
  logic [SEL_W-1:0] r_res_index;
  logic             r_res_valid;
  logic             w_xfer;

  assign w_xfer = r_res_valid & i_res_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE:       if (i_drain_start) w_state_nxt = ST_WAIT_READY;
      ST_WAIT_READY: begin
        if (&i_m_ready_out) begin
          w_state_nxt = ST_CAPTURE;
          w_idx_nxt   = '0;
        end
      end
      ST_CAPTURE:    w_state_nxt = ST_PRESENT;
      ST_PRESENT: begin
        if (w_xfer) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = ST_CAPTURE;
          end
        end
      end
      ST_DONE: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_res_data  <= '0;
      r_res_index <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      // The mux already points at r_idx during CAPTURE, so dataOut is this port's product.
      if (r_state == ST_CAPTURE) begin
        r_res_data  <= i_data_out;
        r_res_index <= r_idx;
        r_res_valid <= 1'b1;
      end else if (r_state == ST_PRESENT && w_xfer) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_output_select = r_idx;
  assign o_res_data      = r_res_data;
  assign o_res_index     = r_res_index;
  assign o_res_valid     = r_res_valid;
  assign o_busy          = (r_state != ST_IDLE);
  assign o_drain_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_xbar_result_drain.sv
// Bench for xbar_result_drain: latency table, multi-cycle corner sequences and
// a randomized phase, all scored against an in-order word queue model.
module tb_xbar_result_drain;
  localparam int PORTS = 4;
  localparam int WIDTH = 32;
  localparam int SEL_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             drain_start = 1'b0;
  logic             res_ready = 1'b1;
  logic [PORTS-1:0] m_ready = '0;
  logic [WIDTH-1:0] data_out;
  logic [SEL_W-1:0] output_select, res_index;
  logic [WIDTH-1:0] res_data;
  logic             res_valid, busy, drain_done;
  logic [WIDTH-1:0] prod [PORTS];

  // Stand-in for the crossbar output mux.
  assign data_out = prod[output_select];

  xbar_result_drain #(.PORTS(PORTS), .WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_drain_start(drain_start), .i_m_ready_out(m_ready),
    .i_data_out(data_out), .o_output_select(output_select), .o_res_data(res_data),
    .o_res_index(res_index), .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_busy(busy), .o_drain_done(drain_done)
  );

  int errors = 0, checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted drain queues every port's product in index order.
  typedef struct { logic [SEL_W-1:0] idx; logic [WIDTH-1:0] data; } word_t;
  word_t exp_q[$];
  word_t w_pop;
  bit    m_active = 0, exp_done = 0;
  int    done_cnt = 0, xfer_cnt = 0;
  bit    prev_hold = 0;
  logic [WIDTH-1:0] hold_data;
  logic [SEL_W-1:0] hold_index;

  task automatic accept_start();
    if (!m_active) begin
      m_active = 1;
      for (int k = 0; k < PORTS; k++) exp_q.push_back('{idx: SEL_W'(k), data: prod[k]});
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      chk("drainDone", drain_done, exp_done);
      if (exp_done) begin m_active = 0; exp_done = 0; end
      if (drain_done) done_cnt++;
      if (prev_hold) begin
        chk("hold_valid", res_valid, 1);
        chk("hold_data", res_data, hold_data);
        chk("hold_index", res_index, hold_index);
      end
      if (res_valid) chk("select_vs_index", output_select, res_index);
      prev_hold  = res_valid && !res_ready;
      hold_data  = res_data;
      hold_index = res_index;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_word: got index %0d data %0h expected no word", res_index, res_data);
        end else begin
          w_pop = exp_q.pop_front();
          chk("word_index", res_index, w_pop.idx);
          chk("word_data", res_data, w_pop.data);
          xfer_cnt++;
          if (exp_q.size() == 0) exp_done = 1;
        end
      end
    end
  end

  // Downstream: random, or low for stall_cfg cycles at the start of each word.
  bit rnd_ready = 0;
  int stall_cfg = 0, stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rnd_ready) res_ready = ($urandom_range(0, 2) != 0);
    else if (res_valid && stall_cnt < stall_cfg) begin res_ready = 0; stall_cnt++; end
    else begin res_ready = 1; stall_cnt = 0; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; drain_start = 0;
    exp_q.delete(); m_active = 0; exp_done = 0;
    tick();
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_index", res_index, 0);
    chk("rst_select", output_select, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    rst = 0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int n = 0;
    while (!drain_done && n < limit) begin tick(); n++; end
    if (!drain_done) begin
      checks++; errors++;
      $display("FAIL %s: got no drainDone within %0d cycles expected a pulse", name, limit);
    end
  endtask

  task automatic wait_valid(input string name, input int idx, input int limit);
    int n = 0;
    while (!(res_valid && res_index == SEL_W'(idx)) && n < limit) begin tick(); n++; end
    if (!(res_valid && res_index == SEL_W'(idx))) begin
      checks++; errors++;
      $display("FAIL %s: got no valid word %0d within %0d cycles expected one", name, idx, limit);
    end
  endtask

  // Cycle 1 is the cycle drainStart is driven; ready drops for wait_c cycles.
  typedef struct {
    int wait_c;
    int stall;
    logic [PORTS-1:0][WIDTH-1:0] p;
    int exp_valid_cyc;
    int exp_done_cyc;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int cyc, first_valid, done_at, x0, d0;
    vecs[0] = '{0, 0, {32'h44, 32'h33, 32'h22, 32'h11}, 4, 11};
    vecs[1] = '{6, 0, {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000}, 9, 16};
    vecs[2] = '{0, 5, {32'hFFFFFFFF, 32'h0, 32'h80000001, 32'h7FFFFFFE}, 4, 31};
    vecs[3] = '{3, 2, {32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h9ABCDEF0}, 6, 21};
    for (int k = 0; k < PORTS; k++) prod[k] = '0;

    do_reset();
    tick();

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < PORTS; k++) prod[k] = vecs[v].p[k];
      stall_cfg = vecs[v].stall;
      m_ready = (vecs[v].wait_c == 0) ? '1 : 4'b0111;
      x0 = xfer_cnt;
      drain_start = 1; accept_start();
      cyc = 1; first_valid = 0; done_at = 0;
      while (cyc < 200 && done_at == 0) begin
        tick(); cyc++;
        drain_start = 0;
        if (cyc - 1 == vecs[v].wait_c) m_ready = '1;
        if (cyc == 2 && vecs[v].wait_c > 1) begin
          chk("wait_busy", busy, 1);
          chk("wait_valid", res_valid, 0);
        end
        if (res_valid && first_valid == 0) first_valid = cyc;
        if (drain_done) done_at = cyc;
      end
      chk("first_valid_cycle", first_valid, vecs[v].exp_valid_cyc);
      chk("drain_done_cycle", done_at, vecs[v].exp_done_cyc);
      tick();
      chk("idle_after_drain", busy, 0);
      chk("words_per_drain", xfer_cnt - x0, PORTS);
    end

    // Start requests during PRESENT and during DONE are dropped.
    stall_cfg = 2; m_ready = '1;
    for (int k = 0; k < PORTS; k++) prod[k] = 32'h100 + k;
    x0 = xfer_cnt; d0 = done_cnt;
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    wait_valid("ign_present", 1, 50);
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    wait_done("ign_done", 100);
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    tick(); tick();
    chk("ign_busy", busy, 0);
    chk("ign_words", xfer_cnt - x0, PORTS);
    chk("ign_done_count", done_cnt - d0, 1);

    // Reset while word 2 is stalled.
    stall_cfg = 20;
    for (int k = 0; k < PORTS; k++) prod[k] = 32'hC0DE0000 + k;
    d0 = done_cnt;
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    wait_valid("rst_reach_word2", 2, 200);
    do_reset();
    tick(); tick(); tick();
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_valid", res_valid, 0);
    stall_cfg = 0; x0 = xfer_cnt;
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    wait_done("rst_fresh", 100);
    tick();
    chk("rst_fresh_words", xfer_cnt - x0, PORTS);
    chk("rst_fresh_done_count", done_cnt - d0, 1);

    // mReady drops once word 0 is captured; drain carries on.
    stall_cfg = 1; m_ready = '1;
    for (int k = 0; k < PORTS; k++) prod[k] = 32'hBEEF0000 + k;
    x0 = xfer_cnt;
    drain_start = 1; accept_start(); tick(); drain_start = 0;
    wait_valid("late_word0", 0, 50);
    m_ready = '0;
    wait_done("late_done", 100);
    tick();
    chk("late_words", xfer_cnt - x0, PORTS);
    chk("late_busy", busy, 0);

    // Randomized traffic.
    rnd_ready = 1;
    for (int i = 0; i < 600; i++) begin
      m_ready = ($urandom_range(0, 1) != 0) ? '1 : PORTS'($urandom);
      drain_start = ($urandom_range(0, 5) == 0);
      if (drain_start && !m_active) begin
        for (int k = 0; k < PORTS; k++) prod[k] = $urandom;
        accept_start();
      end
      tick();
    end
    drain_start = 0; rnd_ready = 0; stall_cfg = 0; m_ready = '1;
    for (int n = 0; n < 100 && m_active; n++) tick();
    tick();
    chk("rnd_settled", m_active, 0);
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_result_drain.md
XBAR_RESULT_DRAIN -- requirements
Module: xbar_result_drain

Interface
REQ-001 Parameter PORTS, default 4: number of crossbar output-side multipliers to drain.
REQ-002 Parameter WIDTH, default 32: data word width, equal to bitLength.
REQ-003 Parameter SEL_W, default 2: outputSelect width, equal to selectorLength; must satisfy 2**SEL_W >= PORTS.
REQ-004 Clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Rst  input  1  synchronous, active-high reset.
REQ-006 drainStart  input  1  request to drain one result set; sampled only in IDLE.
REQ-007 mReady_out  input  PORTS  completion flags from the output-side multipliers.
REQ-008 dataOut  input  WIDTH  product selected by the output mux, combinational from outputSelect.
REQ-009 outputSelect  output  SEL_W  mux select driven to the multiply-crossbar block.
REQ-010 resData  output  WIDTH  registered result word.
REQ-011 resIndex  output  SEL_W  port index of resData.
REQ-012 resValid  output  1  resData/resIndex valid.
REQ-013 resReady  input  1  downstream accept; a transfer occurs when resValid and resReady are both high on a rising edge.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 drainDone  output  1  one-cycle pulse after the last word transfers.

Function
REQ-016 FSM states: IDLE, WAIT_READY, CAPTURE, PRESENT, DONE.
REQ-017 IDLE: drainStart=1 -> WAIT_READY; otherwise stay.
REQ-018 WAIT_READY: mReady_out all ones -> CAPTURE with idx=0; otherwise stay, with no timeout.
REQ-019 mReady_out is sampled only in WAIT_READY; deassertion afterwards has no effect on the drain in progress.
REQ-020 outputSelect = idx in all states; idx = 0 outside CAPTURE/PRESENT.
REQ-021 CAPTURE (one cycle): resData<=dataOut, resIndex<=idx, resValid<=1 -> PRESENT.
REQ-022 PRESENT: resData/resIndex/resValid held stable until transfer.
- On transfer with idx<PORTS-1: resValid<=0, idx<=idx+1 -> CAPTURE.
- On transfer with idx==PORTS-1: resValid<=0 -> DONE.
REQ-023 resValid never asserted outside PRESENT; at most one word in flight; no bubble-free streaming required.
REQ-024 DONE (one cycle): drainDone=1, idx<=0 -> IDLE; drainStart in DONE ignored.
REQ-025 drainStart while busy=1 is ignored and not queued.
REQ-026 Latency: drainStart at edge N with mReady_out all ones -> WAIT_READY at N+1, CAPTURE at N+2, resValid high after edge N+3.
REQ-027 Throughput: with resReady tied high, one word per 2 cycles; full drain takes 2*PORTS+3 cycles from drainStart to drainDone.
REQ-028 resData is an unmodified copy of dataOut; no width change or arithmetic.

Reset
REQ-029 Rst=1 at a rising edge forces IDLE, idx=0, outputSelect=0, resData=0, resIndex=0, resValid=0, busy=0, drainDone=0.
REQ-030 Rst mid-drain abandons the drain with no drainDone and no further resValid; drainStart is ignored during reset cycles.

Structure
REQ-031 FSM state encoding and the PORTS/WIDTH/SEL_W defaults (bitLength, outputPortCount, selectorLength) shall come from the shared definitions header, not be redefined locally.
REQ-032 Single flat module with no sub-modules; instantiated beside multiplyXBar, connected to its outputSelect, dataOut and mReady_out.

Verification
REQ-033 Basic drain: mReady_out=4'b1111; port products 0x11,0x22,0x33,0x44; resReady=1; pulse drainStart -> resData 0x11..0x44 with resIndex 0..3, drainDone 11 cycles after drainStart.
REQ-034 Backpressure: resReady low for 5 cycles on each word -> resData/resIndex held stable, no word lost or duplicated, order 0..3.
REQ-035 Wait: drainStart with mReady_out=4'b0111 for 6 cycles, then 4'b1111 -> stays in WAIT_READY (busy=1, resValid=0), then the first word is valid 2 cycles after ready.
REQ-036 Ignored start: drainStart pulsed during PRESENT and during DONE -> exactly 4 words and one drainDone; returns to IDLE.
REQ-037 Reset mid-drain: Rst during PRESENT of word 2 -> next cycle all outputs 0, no drainDone; a fresh drainStart then drains words 0..3 normally.
REQ-038 Late deassert: mReady_out drops to 0 after CAPTURE of word 0 -> drain still completes all 4 words.
